calc_port_responder: RTL and testbench
======================================

// Module: calc_port_responder
// PURPOSE
//  Single-port responder for the calc request protocol: two-beat request in
//  (command + operand 1, then operand 2), one-beat response out.
//  Same protocol the calc1 benches drive on each req port.
//  Lets the team build multi-port and stub calc models and check bench drivers.
// PARAMETERS
//  DATA_W     32  operand/result width; bit 0 is the MSB, bit DATA_W-1 the LSB.
//  EXTRA_LAT   0  extra response pipeline stages, legal range 0..3.
// PORTS
//  c_clk        in   1       clock; all logic on the rising edge.
//  reset        in   1       synchronous, active-high reset.
//  req_cmd_in   in   4       command: 0 none, 1 add, 2 sub, 5 shl, 6 shr, others invalid.
//  req_data_in  in   DATA_W  operand 1 on the command cycle, operand 2 on the next cycle.
//  out_resp     out  2       response: 0 none, 1 success, 2 overflow/underflow/invalid, 3 never.
//  out_data     out  DATA_W  result; 0 whenever out_resp != 1.
//  busy         out  1       high from the cycle after acceptance until the response beat.
// BEHAVIOUR
//  Reset: state IDLE; out_resp=0, out_data=0, busy=0; operand regs cleared.
//   Applies on the first edge with reset=1.
//  FSM states: IDLE -> OP2 -> [WAIT x EXTRA_LAT] -> RESP -> IDLE, or -> OP2 when a cmd is accepted in RESP.
//  Accept: in IDLE or RESP, req_cmd_in != 0 at edge T latches cmd and operand 1.
//   OP2: at edge T+1 latch operand 2 unconditionally.
//   req_cmd_in is ignored during OP2 and WAIT; commands arriving there are dropped, not queued.
//  Response: out_resp/out_data valid for exactly one cycle, following edge T+2+EXTRA_LAT.
//   Both outputs return to 0 the next cycle unless a new response is due.
//   Back-to-back: a cmd accepted in RESP gives its response 2+EXTRA_LAT cycles later.
//  add: 33-bit sum; carry out -> resp 2, data 0; else resp 1, data = sum.
//  sub: op2 > op1 (unsigned) -> resp 2, data 0; else resp 1, data = op1 - op2.
//   Equal operands -> resp 1, data 0.
//  shl/shr: shift count is the 5 LSBs of op2 (op2[DATA_W-5 +: 5]); upper op2 bits ignored.
//   Vacated bits are zero-filled; bits shifted out are lost; never an error; count 0 -> data = op1.
//  Invalid cmd (3,4,7..15): still consumes the op2 beat; resp 2, data 0 at the normal latency.
//  Reset mid-operation: request discarded, no response beat, outputs 0 after the edge.
//  busy=1 in OP2, WAIT and RESP; busy=0 in IDLE.
// CONFIGURATION
//  CALC_ERR_CNT_EN defined:
//   Adds output port err_count [8]: saturating count of resp-2 beats.
//   Cleared by reset; holds at 255; increments on the edge that drives resp 2.
//  CALC_ERR_CNT_EN undefined: no err_count port and no counter logic; otherwise identical.
// TESTING
//  1 Reset 4 cycles; add 0x00000001 then 0x1FFFFFFF -> resp 1, data 0x20000000 at T+2, 0/0 at T+3.
//  2 Add 0xFFFFFFFF then 0x00000001 -> resp 2, data 0.
//    With CALC_ERR_CNT_EN: err_count 0 -> 1.
//  3 Sub 0x1 - 0xF -> resp 2, data 0; sub 0xF - 0x1 -> resp 1, data 0xE; sub 5 - 5 -> resp 1, data 0.
//  4 Cmds 3 and 4 with op1=1 -> resp 2, data 0 at T+2; cmd 1 during OP2 -> ignored, one response only.
//  5 Shl 0x1 by n, n=0..31 -> 1<<n; shr 0x80000000 by 31 -> 0x1; shl by op2=0x21 -> shift 1.
//  6 Reset during OP2 -> no response beat; back-to-back adds accepted in RESP -> two responses 2 cycles apart.
//    Repeat with EXTRA_LAT=2: responses at T+4.

Source files
------------

// File: rtl/calc_port_responder.sv
// Single-port responder for the two-beat calc request protocol (cmd+op1, then op2).
// Optional CALC_ERR_CNT_EN adds a saturating err_count output of error response beats.
module calc_port_responder #(
    parameter int DATA_W    = 32,
    parameter int EXTRA_LAT = 0
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req_cmd_in,
    input  logic [0:DATA_W-1] req_data_in,
    output logic [1:0]        out_resp,
    output logic [0:DATA_W-1] out_data,
    output logic              busy
`ifdef CALC_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] LAT_INIT = (EXTRA_LAT > 0) ? 2'(EXTRA_LAT - 1) : 2'd0;

    state_t              state_q, state_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [0:DATA_W-1]   op1_q, op1_d;
    logic [0:DATA_W-1]   op2_q, op2_d;
    logic [1:0]          lat_q, lat_d;
    logic [1:0]          resp_q, resp_d;
    logic [0:DATA_W-1]   data_q, data_d;
    logic                busy_q, busy_d;

    logic [DATA_W:0]     sum_s;
    logic [4:0]          shamt_s;
    logic [1:0]          res_resp_s;
    logic [0:DATA_W-1]   res_data_s;

    // Result of the latched operation; the shift count is the 5 LSBs of op2.
    always_comb begin
        sum_s      = {1'b0, op1_q} + {1'b0, op2_q};
        shamt_s    = op2_q[DATA_W-5 +: 5];
        res_resp_s = 2'd2;
        res_data_s = '0;
        case (cmd_q)
            4'd1: begin
                if (sum_s[DATA_W]) begin
                    res_resp_s = 2'd2;
                end else begin
                    res_resp_s = 2'd1;
                    res_data_s = sum_s[DATA_W-1:0];
                end
            end
            4'd2: begin
                if (op2_q > op1_q) begin
                    res_resp_s = 2'd2;
                end else begin
                    res_resp_s = 2'd1;
                    res_data_s = op1_q - op2_q;
                end
            end
            4'd5: begin
                res_resp_s = 2'd1;
                res_data_s = op1_q << shamt_s;
            end
            4'd6: begin
                res_resp_s = 2'd1;
                res_data_s = op1_q >> shamt_s;
            end
            default: begin
                res_resp_s = 2'd2;
                res_data_s = '0;
            end
        endcase
    end

    // Next-state and registered-output decode; outputs default to 0 outside RESP.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        lat_d   = lat_q;
        resp_d  = 2'd0;
        data_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_cmd_in != 4'd0) begin
                    state_d = ST_OP2;
                    cmd_d   = req_cmd_in;
                    op1_d   = req_data_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OP2: begin
                op2_d = req_data_in;
                if (EXTRA_LAT == 0) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_INIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_RESP: begin
                resp_d = res_resp_s;
                data_d = res_data_s;
                if (req_cmd_in != 4'd0) begin
                    state_d = ST_OP2;
                    cmd_d   = req_cmd_in;
                    op1_d   = req_data_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= 4'd0;
            op1_q   <= '0;
            op2_q   <= '0;
            lat_q   <= 2'd0;
            resp_q  <= 2'd0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            lat_q   <= lat_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign out_resp = resp_q;
    assign out_data = data_q;
    assign busy     = busy_q;

`ifdef CALC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of error beats, bumped on the edge that drives resp 2.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((resp_d == 2'd2) && (err_cnt_q != 8'd255)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder: one instance at EXTRA_LAT=0, one at EXTRA_LAT=2.
module tb_calc_port_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cmd0, cmd1;
    logic [0:31] d0, d1;
    logic [1:0]  resp0, resp1;
    logic [0:31] q0, q1;
    logic        busy0, busy1;
`ifdef CALC_ERR_CNT_EN
    logic [7:0]  errc0, errc1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    calc_port_responder #(.DATA_W(32), .EXTRA_LAT(0)) dut0 (
        .c_clk(clk), .reset(rst), .req_cmd_in(cmd0), .req_data_in(d0),
        .out_resp(resp0), .out_data(q0), .busy(busy0)
`ifdef CALC_ERR_CNT_EN
        , .err_count(errc0)
`endif
    );

    calc_port_responder #(.DATA_W(32), .EXTRA_LAT(2)) dut1 (
        .c_clk(clk), .reset(rst), .req_cmd_in(cmd1), .req_data_in(d1),
        .out_resp(resp1), .out_data(q1), .busy(busy1)
`ifdef CALC_ERR_CNT_EN
        , .err_count(errc1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction on dut0, called at a negedge; response expected after edge T+2.
    task automatic op0(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
        cmd0 = c; d0 = a;
        @(negedge clk);
        cmd0 = 4'd0; d0 = b;
        chk({tag, ".busy_op2"}, 32'(busy0), 32'd1);
        chk({tag, ".resp_op2"}, 32'(resp0), 32'd0);
        @(negedge clk);
        d0 = 32'd0;
        chk({tag, ".resp_early"}, 32'(resp0), 32'd0);
        @(negedge clk);
        chk({tag, ".resp"}, 32'(resp0), 32'(er));
        chk({tag, ".data"}, q0, ed);
        chk({tag, ".busy_after"}, 32'(busy0), 32'd0);
        @(negedge clk);
        chk({tag, ".resp_clr"}, 32'(resp0), 32'd0);
        chk({tag, ".data_clr"}, q0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd0 = 4'd0; cmd1 = 4'd0; d0 = 32'd0; d1 = 32'd0;
        repeat (4) @(negedge clk);
        chk("rst.resp0", 32'(resp0), 32'd0);
        chk("rst.data0", q0, 32'd0);
        chk("rst.busy0", 32'(busy0), 32'd0);
        chk("rst.resp1", 32'(resp1), 32'd0);
        chk("rst.busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op0("add_ok", 4'd1, 32'h00000001, 32'h1FFFFFFF, 2'd1, 32'h20000000);
`ifdef CALC_ERR_CNT_EN
        chk("errc.before", 32'(errc0), 32'd0);
`endif
        op0("add_ovf", 4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h0);
`ifdef CALC_ERR_CNT_EN
        chk("errc.after", 32'(errc0), 32'd1);
`endif
        op0("sub_udf", 4'd2, 32'h1, 32'hF, 2'd2, 32'h0);
        op0("sub_ok", 4'd2, 32'hF, 32'h1, 2'd1, 32'hE);
        op0("sub_eq", 4'd2, 32'h5, 32'h5, 2'd1, 32'h0);
        op0("inv3", 4'd3, 32'h1, 32'h2, 2'd2, 32'h0);
        op0("inv4", 4'd4, 32'h1, 32'h2, 2'd2, 32'h0);
        op0("inv15", 4'd15, 32'h7, 32'h7, 2'd2, 32'h0);

        // cmd 1 arriving in OP2 must be dropped: one response only
        cmd0 = 4'd3; d0 = 32'h1;
        @(negedge clk);
        cmd0 = 4'd1; d0 = 32'h4;
        @(negedge clk);
        cmd0 = 4'd0; d0 = 32'h0;
        @(negedge clk);
        chk("drop.resp", 32'(resp0), 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drop.no_second", 32'(resp0), 32'd0);
        end
        chk("drop.busy", 32'(busy0), 32'd0);

        for (int n = 0; n < 32; n++) begin
            op0("shl_n", 4'd5, 32'h1, 32'(n), 2'd1, 32'h1 << n);
        end
        op0("shr_31", 4'd6, 32'h80000000, 32'd31, 2'd1, 32'h1);
        op0("shl_21", 4'd5, 32'h1, 32'h21, 2'd1, 32'h2);
        op0("shr_0", 4'd6, 32'hA5A5A5A5, 32'hFFFFFFE0, 2'd1, 32'hA5A5A5A5);

        // reset during OP2 discards the request
        cmd0 = 4'd1; d0 = 32'h3;
        @(negedge clk);
        cmd0 = 4'd0; d0 = 32'h4; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst.busy", 32'(busy0), 32'd0);
        chk("mid_rst.resp", 32'(resp0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst.no_resp", 32'(resp0), 32'd0);
        end

        // back-to-back on dut0: second cmd accepted in RESP
        cmd0 = 4'd1; d0 = 32'd1;
        @(negedge clk);
        cmd0 = 4'd0; d0 = 32'd2;
        @(negedge clk);
        cmd0 = 4'd1; d0 = 32'd10;
        @(negedge clk);
        cmd0 = 4'd0; d0 = 32'd20;
        chk("b2b.resp1", 32'(resp0), 32'd1);
        chk("b2b.data1", q0, 32'd3);
        chk("b2b.busy1", 32'(busy0), 32'd1);
        @(negedge clk);
        d0 = 32'd0;
        chk("b2b.gap", 32'(resp0), 32'd0);
        @(negedge clk);
        chk("b2b.resp2", 32'(resp0), 32'd1);
        chk("b2b.data2", q0, 32'd30);
        chk("b2b.busy2", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("b2b.clr", 32'(resp0), 32'd0);

        // dut1 (EXTRA_LAT=2): response after edge T+4, back-to-back 4 cycles apart
        cmd1 = 4'd1; d1 = 32'd100;
        @(negedge clk);
        cmd1 = 4'd0; d1 = 32'd23;
        @(negedge clk);
        d1 = 32'd0;
        for (int i = 0; i < 2; i++) begin
            chk("lat2.wait_resp", 32'(resp1), 32'd0);
            chk("lat2.wait_busy", 32'(busy1), 32'd1);
            @(negedge clk);
        end
        chk("lat2.pre_resp", 32'(resp1), 32'd0);
        cmd1 = 4'd2; d1 = 32'd50;
        @(negedge clk);
        cmd1 = 4'd0; d1 = 32'd8;
        chk("lat2.resp1", 32'(resp1), 32'd1);
        chk("lat2.data1", q1, 32'd123);
        @(negedge clk);
        d1 = 32'd0;
        for (int i = 0; i < 3; i++) begin
            chk("lat2.b2b_gap", 32'(resp1), 32'd0);
            @(negedge clk);
        end
        chk("lat2.resp2", 32'(resp1), 32'd1);
        chk("lat2.data2", q1, 32'd42);
        chk("lat2.busy_end", 32'(busy1), 32'd0);
        @(negedge clk);
        chk("lat2.clr", 32'(resp1), 32'd0);
        chk("lat2.clr_data", q1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
